// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: exception codes,
// bubble PC, the T_new type and its saturating decrement.
package pipe_pkg;

    localparam int EXC_W  = 5;
    localparam int TNEW_W = 2;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    localparam logic [31:0] BUBBLE_PC = 32'hFFFF_FFFF;

    typedef logic [TNEW_W-1:0] tnew_t;

    // An instruction whose result is already available stays at 0.
    function automatic tnew_t tnew_dec(input tnew_t t);
        return (t == '0) ? '0 : t - tnew_t'(1);
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Event counters for one pipeline stage register: stall, bubble and flush
// cycles. Each wraps at 2^32 and is cleared by the synchronous reset.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_bubble,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_bubble_cnt,
    output logic [31:0] o_flush_cnt
);

    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_bubble_evt;

    // Events follow the stage register's own priority, so a bubble hidden
    // behind a stall or flush is not counted.
    assign w_stall_evt  = i_stall & ~i_flush;
    assign w_bubble_evt = i_bubble & ~i_stall & ~i_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_stall_evt)  r_stall_cnt  <= r_stall_cnt + 32'd1;
            if (w_bubble_evt) r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (i_flush)      r_flush_cnt  <= r_flush_cnt + 32'd1;
        end
    end

    assign o_stall_cnt  = r_stall_cnt;
    assign o_bubble_cnt = r_bubble_cnt;
    assign o_flush_cnt  = r_flush_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with
// bubble mode, exception merging and link generation. Counters: PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                PAYLOAD_W   = 64,
    parameter int                DATA_W      = 32,
    parameter int                TNEW_W      = 2,
    parameter int                EXC_W       = 5,
    parameter logic [DATA_W-1:0] BUBBLE_PC   = DATA_W'(pipe_pkg::BUBBLE_PC),
    parameter int                LINK_OFFSET = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 bubble,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [DATA_W-1:0]    in_pc,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic [EXC_W-1:0]     in_exc,
    input  logic                 in_local_exc,
    input  logic [EXC_W-1:0]     in_local_code,
    input  logic                 in_bd,
    input  logic                 in_regwe,
    input  logic [4:0]           in_regdst,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [DATA_W-1:0]    out_pc,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic [EXC_W-1:0]     out_exc,
    output logic                 out_bd,
    output logic                 out_regwe,
    output logic [4:0]           out_regdst,
    output logic [DATA_W-1:0]    out_link
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_bubble_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [DATA_W-1:0]    r_pc;
    logic [TNEW_W-1:0]    r_tnew;
    logic [EXC_W-1:0]     r_exc;
    logic                 r_bd;
    logic                 r_regwe;
    logic [4:0]           r_regdst;
    logic [DATA_W-1:0]    r_link;

    logic                 w_valid;
    logic [PAYLOAD_W-1:0] w_payload;
    logic [DATA_W-1:0]    w_pc;
    logic [TNEW_W-1:0]    w_tnew;
    logic [EXC_W-1:0]     w_exc;
    logic                 w_bd;
    logic                 w_regwe;
    logic [4:0]           w_regdst;
    logic [DATA_W-1:0]    w_link;

    logic [TNEW_W-1:0]    w_tnew_dec;
    logic [EXC_W-1:0]     w_exc_merged;
    logic [DATA_W-1:0]    w_link_sum;

    generate
        if (TNEW_W == $bits(tnew_t)) begin : g_tnew_pkg
            assign w_tnew_dec = tnew_dec(in_tnew);
        end else begin : g_tnew_gen
            assign w_tnew_dec = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
        end
    endgenerate

    // Earlier-stage exception has priority over one detected here.
    assign w_exc_merged = (in_exc != EXC_W'(EXC_NONE)) ? in_exc :
                          (in_local_exc ? in_local_code : EXC_W'(EXC_NONE));

    assign w_link_sum = in_pc + DATA_W'(LINK_OFFSET);

    // Next state for a non-stalled cycle; reset and stall are handled at the flops.
    always_comb begin
        w_valid   = 1'b0;
        w_payload = '0;
        w_pc      = BUBBLE_PC;
        w_tnew    = '0;
        w_exc     = '0;
        w_bd      = 1'b0;
        w_regwe   = 1'b0;
        w_regdst  = '0;
        w_link    = '0;
        if (flush) begin
            // full clear, defaults stand
        end else if (bubble || !in_valid) begin
            // Empty slot still carries PC/BD so CP0 can report EPC for it.
            w_pc = in_pc;
            w_bd = in_bd;
        end else begin
            w_valid   = 1'b1;
            w_payload = in_payload;
            w_pc      = in_pc;
            w_tnew    = w_tnew_dec;
            w_exc     = w_exc_merged;
            w_bd      = in_bd;
            w_regwe   = in_regwe;
            w_regdst  = in_regdst;
            w_link    = w_link_sum;
        end
    end

    // Flush must beat stall, so a stalled cycle only holds when not flushing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
            r_pc      <= BUBBLE_PC;
            r_tnew    <= '0;
            r_exc     <= '0;
            r_bd      <= 1'b0;
            r_regwe   <= 1'b0;
            r_regdst  <= '0;
            r_link    <= '0;
        end else if (flush || !stall) begin
            r_valid   <= w_valid;
            r_payload <= w_payload;
            r_pc      <= w_pc;
            r_tnew    <= w_tnew;
            r_exc     <= w_exc;
            r_bd      <= w_bd;
            r_regwe   <= w_regwe;
            r_regdst  <= w_regdst;
            r_link    <= w_link;
        end
    end

    assign out_valid   = r_valid;
    assign out_payload = r_payload;
    assign out_pc      = r_pc;
    assign out_tnew    = r_tnew;
    assign out_exc     = r_exc;
    assign out_bd      = r_bd;
    assign out_regwe   = r_regwe;
    assign out_regdst  = r_regdst;
    assign out_link    = r_link;

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_cnt u_perf (
        .clk          (clk),
        .reset        (reset),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_bubble     (bubble),
        .o_stall_cnt  (perf_stall_cnt),
        .o_bubble_cnt (perf_bubble_cnt),
        .o_flush_cnt  (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors push hand-computed
// expected outputs; a monitor pops and compares one entry per clock.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        v;
        logic [63:0] pl;
        logic [31:0] pc;
        logic [1:0]  tn;
        logic [4:0]  exc;
        logic        bd;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] lk;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, bubble = 1'b0;
    logic        in_valid = 1'b0, in_local_exc = 1'b0, in_bd = 1'b0, in_regwe = 1'b0;
    logic [63:0] in_payload = '0;
    logic [31:0] in_pc = '0;
    logic [1:0]  in_tnew = '0;
    logic [4:0]  in_exc = '0, in_local_code = '0, in_regdst = '0;

    logic        out_valid, out_bd, out_regwe;
    logic [63:0] out_payload;
    logic [31:0] out_pc, out_link;
    logic [1:0]  out_tnew;
    logic [4:0]  out_exc, out_regdst;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc_n  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .bubble(bubble),
        .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc), .in_tnew(in_tnew),
        .in_exc(in_exc), .in_local_exc(in_local_exc), .in_local_code(in_local_code),
        .in_bd(in_bd), .in_regwe(in_regwe), .in_regdst(in_regdst),
        .out_valid(out_valid), .out_payload(out_payload), .out_pc(out_pc),
        .out_tnew(out_tnew), .out_exc(out_exc), .out_bd(out_bd), .out_regwe(out_regwe),
        .out_regdst(out_regdst), .out_link(out_link)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    function automatic exp_t E(logic v, logic [63:0] pl, logic [31:0] pc, logic [1:0] tn,
                               logic [4:0] exc, logic bd, logic we, logic [4:0] rd,
                               logic [31:0] lk);
        exp_t e;
        e.v = v; e.pl = pl; e.pc = pc; e.tn = tn; e.exc = exc;
        e.bd = bd; e.we = we; e.rd = rd; e.lk = lk;
        return e;
    endfunction

    // ctl = {reset, flush, stall, bubble}
    task automatic step(input bit nowait, input logic [3:0] ctl, input logic v,
                        input logic [63:0] pl, input logic [31:0] pc, input logic [1:0] tn,
                        input logic [4:0] ex, input logic le, input logic [4:0] lc,
                        input logic bd, input logic we, input logic [4:0] rd, input exp_t e);
        if (!nowait) @(negedge clk);
        {reset, flush, stall, bubble} = ctl;
        in_valid = v; in_payload = pl; in_pc = pc; in_tnew = tn; in_exc = ex;
        in_local_exc = le; in_local_code = lc; in_bd = bd; in_regwe = we; in_regdst = rd;
        q.push_back(e);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, req);
        end
    endtask

    // Monitor: one expected entry per clock edge that had stimulus applied.
    always @(posedge clk) begin
        exp_t a, e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            a = {out_valid, out_payload, out_pc, out_tnew, out_exc, out_bd, out_regwe,
                 out_regdst, out_link};
            cyc_n++;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle%0d: got v=%b pl=%h pc=%h tn=%0d exc=%0d bd=%b we=%b rd=%0d lk=%h expected v=%b pl=%h pc=%h tn=%0d exc=%0d bd=%b we=%b rd=%0d lk=%h",
                         cyc_n, a.v, a.pl, a.pc, a.tn, a.exc, a.bd, a.we, a.rd, a.lk,
                         e.v, e.pl, e.pc, e.tn, e.exc, e.bd, e.we, e.rd, e.lk);
            end
        end
    end

    initial begin
        exp_t CLR, L;
        CLR = E(0, 64'h0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0);

        // reset held with a valid instruction presented
        step(0, 4'b1000, 1, 64'h11, 32'h3000, 2, 0, 0, 0, 0, 1, 3, CLR);
        step(0, 4'b1000, 1, 64'h11, 32'h3000, 2, 0, 0, 0, 0, 1, 3, CLR);
        // tnew 2 -> 1, link = pc + 8
        step(0, 4'b0000, 1, 64'hA5, 32'h3004, 2, 0, 0, 0, 0, 1, 5,
             E(1, 64'hA5, 32'h3004, 1, 0, 0, 1, 5, 32'h300C));
        // tnew 0 saturates; earlier exception 4 beats local 10
        step(0, 4'b0000, 1, 64'hA6, 32'h3008, 0, 4, 1, 10, 0, 1, 6,
             E(1, 64'hA6, 32'h3008, 0, 4, 0, 1, 6, 32'h3010));
        // no earlier exception: local code 10 used; tnew 3 -> 2
        step(0, 4'b0000, 1, 64'hA7, 32'h300C, 3, 0, 1, 10, 1, 0, 0,
             E(1, 64'hA7, 32'h300C, 2, 10, 1, 0, 0, 32'h3014));
        // hazard bubble keeps PC/BD only
        step(0, 4'b0001, 1, 64'hA8, 32'h3010, 2, 3, 1, 5, 1, 1, 9,
             E(0, 64'h0, 32'h3010, 0, 0, 1, 0, 0, 32'h0));
        L = E(1, 64'hB6, 32'h3014, 1, 0, 0, 1, 7, 32'h301C);
        step(0, 4'b0000, 1, 64'hB6, 32'h3014, 2, 0, 0, 0, 0, 1, 7, L);
        // three stalled cycles with changing inputs (one with bubble): hold
        step(0, 4'b0010, 1, 64'hFF, 32'h4000, 3, 12, 0, 0, 1, 0, 1, L);
        step(0, 4'b0011, 0, 64'hFE, 32'h4004, 2, 0, 1, 4, 0, 1, 2, L);
        step(0, 4'b0010, 1, 64'hFD, 32'h4008, 0, 5, 0, 0, 1, 1, 3, L);
        // flush beats stall
        step(0, 4'b0110, 1, 64'hFC, 32'h400C, 2, 0, 0, 0, 1, 1, 4, CLR);
        // invalid slot: stale exception and regwe dropped, PC/BD kept
        step(0, 4'b0000, 0, 64'hC0, 32'h5000, 3, 12, 1, 4, 1, 1, 8,
             E(0, 64'h0, 32'h5000, 0, 0, 1, 0, 0, 32'h0));
        // link wraps; local_exc with code 0 yields no exception
        step(0, 4'b0000, 1, 64'hC1, 32'hFFFF_FFFC, 1, 0, 1, 0, 0, 1, 2,
             E(1, 64'hC1, 32'hFFFF_FFFC, 0, 0, 0, 1, 2, 32'h4));
        step(0, 4'b0000, 1, 64'hC2, 32'h3020, 1, 5, 0, 0, 0, 1, 4,
             E(1, 64'hC2, 32'h3020, 0, 5, 0, 1, 4, 32'h3028));
        // reset during stall still clears
        step(0, 4'b1010, 1, 64'hC3, 32'h3024, 2, 0, 0, 0, 0, 1, 5, CLR);

        // counter scenario: 3 stall, 2 bubble, 1 flush
        step(0, 4'b0010, 1, 64'hD0, 32'h6000, 2, 0, 0, 0, 0, 1, 1, CLR);
        step(0, 4'b0010, 1, 64'hD0, 32'h6000, 2, 0, 0, 0, 0, 1, 1, CLR);
        step(0, 4'b0010, 1, 64'hD0, 32'h6000, 2, 0, 0, 0, 0, 1, 1, CLR);
        step(0, 4'b0001, 1, 64'hD1, 32'h6000, 2, 0, 0, 0, 0, 1, 1,
             E(0, 64'h0, 32'h6000, 0, 0, 0, 0, 0, 32'h0));
        step(0, 4'b0001, 1, 64'hD2, 32'h6004, 2, 0, 0, 0, 1, 1, 1,
             E(0, 64'h0, 32'h6004, 0, 0, 1, 0, 0, 32'h0));
        step(0, 4'b0100, 1, 64'hD3, 32'h6008, 2, 0, 0, 0, 0, 1, 1, CLR);
        @(negedge clk);
`ifdef PIPE_STAGE_PERF_EN
        chk32("perf_stall_cnt", perf_stall_cnt, 32'd3);
        chk32("perf_bubble_cnt", perf_bubble_cnt, 32'd2);
        chk32("perf_flush_cnt", perf_flush_cnt, 32'd1);
`endif
        step(1, 4'b1000, 1, 64'hE0, 32'h7000, 1, 0, 0, 0, 0, 1, 1, CLR);
        @(negedge clk);
`ifdef PIPE_STAGE_PERF_EN
        chk32("perf_stall_cnt_rst", perf_stall_cnt, 32'd0);
        chk32("perf_bubble_cnt_rst", perf_bubble_cnt, 32'd0);
        chk32("perf_flush_cnt_rst", perf_flush_cnt, 32'd0);
`endif
        step(1, 4'b0000, 1, 64'hE1, 32'h7004, 1, 0, 0, 0, 0, 1, 1,
             E(1, 64'hE1, 32'h7004, 0, 0, 0, 1, 1, 32'h700C));

        repeat (3) @(negedge clk);
        chk32("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
